// File: rtl/servo_pkg.sv
// Shared types, default constants and helpers for the servo motion sequencer.
package servo_pkg;

  localparam int unsigned DEFAULT_PERIOD     = 2000000;
  localparam int unsigned DEFAULT_MIN_WIDTH  = 100000;
  localparam int unsigned DEFAULT_MAX_WIDTH  = 200000;
  localparam int unsigned DEFAULT_HOME_WIDTH = 150000;

  typedef logic [31:0] width_t;

  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StRamp   = 2'd1;
  localparam state_t StSettle = 2'd2;

  function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

endpackage

// File: rtl/servo_sequencer_if.sv
// Command handshake between the drawing-path command source and the sequencer.
interface servo_sequencer_if #(
  parameter int unsigned N_SERVO = 3
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [32*N_SERVO-1:0]  cmd_target;
  logic [31:0]            cmd_step;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/servo_slew.sv
// One servo channel: moves its width toward the target by at most one step per update.
module servo_slew
  import servo_pkg::*;
#(
  parameter width_t HOME_WIDTH = width_t'(DEFAULT_HOME_WIDTH)
) (
  input  logic   clk,
  input  logic   rst,
  input  width_t target,
  input  width_t step,
  input  logic   update,
  input  logic   freeze,
  output width_t width,
  output logic   at_target
);

  width_t width_q, width_d, diff;

  // Magnitude is taken before subtracting so the unsigned math never wraps.
  always_comb begin
    diff = (target >= width_q) ? (target - width_q) : (width_q - target);
    if (step == '0 || diff <= step) begin
      width_d = target;
    end else if (target > width_q) begin
      width_d = width_q + step;
    end else begin
      width_d = width_q - step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q <= HOME_WIDTH;
    end else if (update && !freeze) begin
      width_q <= width_d;
    end
  end

  assign width = width_q;
  // Reports the post-update position so the FSM can leave RAMP on the same tick.
  assign at_target = (width_d == target);

endmodule

// File: rtl/servo_sequencer.sv
// Frame-synchronous motion sequencer: ramps N servo widths to a target, settles, then reports done.
module servo_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned N_SERVO       = 3,
  parameter int unsigned PERIOD        = DEFAULT_PERIOD,
  parameter int unsigned MIN_WIDTH     = DEFAULT_MIN_WIDTH,
  parameter int unsigned MAX_WIDTH     = DEFAULT_MAX_WIDTH,
  parameter int unsigned HOME_WIDTH    = DEFAULT_HOME_WIDTH,
  parameter int unsigned SETTLE_FRAMES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  servo_sequencer_if.slave      cmd,
  input  logic                  abort,
  output logic [32*N_SERVO-1:0] width_out,
  output logic                  frame_tick,
  output logic                  busy,
  output logic                  done
);

  logic [31:0]          frame_cnt_q;
  state_t               state_q, state_d;
  logic [31:0]          settle_cnt_q, settle_cnt_d;
  width_t               target_q [N_SERVO];
  width_t               step_q;
  width_t               slew_width [N_SERVO];
  logic [N_SERVO-1:0]   at_target;
  logic                 all_at_target;
  logic                 accept;
  logic                 update;
  logic                 freeze;

  // Free-running frame counter, independent of the FSM.
  assign frame_tick = (frame_cnt_q == PERIOD - 1);

  always_ff @(posedge clk) begin
    if (rst || frame_tick) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign accept        = cmd.cmd_ready && cmd.cmd_valid;
  assign busy          = (state_q != StIdle);
  assign all_at_target = &at_target;
  assign update        = frame_tick && (state_q == StRamp);
  assign freeze        = abort && busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SERVO; i++) begin
        target_q[i] <= width_t'(HOME_WIDTH);
      end
      step_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_SERVO; i++) begin
        target_q[i] <= clamp_width(cmd.cmd_target[32*i +: 32], width_t'(MIN_WIDTH),
                                   width_t'(MAX_WIDTH));
      end
      step_q <= cmd.cmd_step;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    done         = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          state_d = StRamp;
        end
      end
      StRamp: begin
        if (abort) begin
          state_d = StIdle;
        end else if (frame_tick && all_at_target) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_cnt_q == SETTLE_FRAMES) begin
          // Checked before counting so SETTLE_FRAMES == 0 exits without a tick.
          done    = !rst;
          state_d = StIdle;
        end else if (frame_tick) begin
          settle_cnt_d = settle_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  for (genvar g = 0; g < N_SERVO; g++) begin : g_slew
    servo_slew #(
      .HOME_WIDTH (width_t'(HOME_WIDTH))
    ) u_slew (
      .clk       (clk),
      .rst       (rst),
      .target    (target_q[g]),
      .step      (step_q),
      .update    (update),
      .freeze    (freeze),
      .width     (slew_width[g]),
      .at_target (at_target[g])
    );
    assign width_out[32*g +: 32] = slew_width[g];
  end

endmodule

// File: doc/servo_sequencer.md
# servo_sequencer

Motion controller sitting between the drawing-path command source and the `servo_driver` PWM instances. Accepts one target pulse-width set for N servos per command, slews each channel toward its target by at most a programmed step per PWM frame, waits a settle interval, then signals completion. Width outputs change only on frame boundaries, which prevents mechanical jerk and keeps commanded widths inside the safe servo range.

## Interface
- `N_SERVO`, 3: number of servo channels (pen lift, shoulder, elbow).
- `PERIOD`, 2000000: clocks per PWM frame.
- `MIN_WIDTH`, 100000: lowest legal width, in clocks.
- `MAX_WIDTH`, 200000: highest legal width, in clocks.
- `HOME_WIDTH`, 150000: width driven after reset.
- `SETTLE_FRAMES`, 10: frames to hold after all channels reach target.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_target` in 32*N_SERVO: per-channel target width; channel i is bits [32i+31:32i].
- `cmd_step` in 32: maximum width change per frame, shared by all channels. 0 means jump.
- `abort` in 1: stop the motion in progress.
- `width_out` out 32*N_SERVO: per-channel width to `servo_driver.width`.
- `frame_tick` out 1: one-cycle pulse at frame boundary.
- `busy` out 1: motion or settle in progress.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- Frame counter counts 0..PERIOD-1 and wraps. It runs free and is independent of state. `frame_tick` = 1 when count == PERIOD-1.
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid` the block latches the targets, clamped to [MIN_WIDTH, MAX_WIDTH], and the step, then moves to RAMP.
  - RAMP: on each `frame_tick`, every channel updates. If |target−cur| ≤ step or step==0, cur←target. Otherwise cur←cur±step toward target. Once all channels equal their targets after an update, the block moves to SETTLE with settle count 0.
  - SETTLE: each `frame_tick` increments the settle count. When it reaches SETTLE_FRAMES, the block pulses `done` and moves to IDLE.
- Arithmetic: 32-bit unsigned. The comparison is made before the subtraction, so no underflow occurs. Clamped targets keep all values in range.
- SETTLE_FRAMES=0 means the block leaves SETTLE on the first cycle in that state, with no tick needed.
- `abort` in RAMP or SETTLE: `width_out` freezes at its current values, the block goes to IDLE next cycle, and `done` is not pulsed. `abort` in IDLE is ignored, including when it arrives together with `cmd_valid`; the command is accepted.
- `abort` coinciding with `frame_tick` in RAMP: abort wins and no width update happens that cycle.
- Command already at target in RAMP: the first tick produces no change and the block enters SETTLE.
- `busy` = state != IDLE.

## Timing
- Reset values: `width_out`=HOME_WIDTH on every channel, frame count 0, state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `frame_tick`=0.
- Reset mid-motion returns to the reset values on the next edge and discards the latched command.
- Handshake: transfer happens on a cycle with `cmd_valid`&&`cmd_ready`. `cmd_ready` drops the cycle after acceptance. Inputs are sampled only on the transfer cycle.
- `width_out` is registered and changes only on the cycle after a `frame_tick` cycle.
- Latency from acceptance to first width change: the next `frame_tick` plus 1 cycle, which is at most PERIOD+1 cycles.
- Total motion: ceil(max|Δ|/step) ramp ticks + SETTLE_FRAMES ticks. `done` occurs 1 cycle after the final tick.
- `cmd_ready` returns high the cycle after `done`.

## Structure
- Package `servo_pkg`: default constants MIN_WIDTH, MAX_WIDTH, PERIOD and HOME_WIDTH; state enum {IDLE, RAMP, SETTLE}; width type (32-bit).
- Sub-module `servo_slew`, instantiated N_SERVO times. Inputs: target, step, update enable, freeze. Outputs: registered current width and an at_target flag.
- The top level owns the frame counter, FSM, settle counter and handshake, and ANDs the at_target flags together.

## Test plan
All scenarios use PERIOD=100 and SETTLE_FRAMES=2.
- Reset, then no command → `width_out`=150000 on all channels; `frame_tick` every 100 cycles; `busy`=0.
- Target {150300, 149800, 150000}, step 100 → channel 0 ramps 150100/150200/150300 and channel 1 ramps 149900/149800. `done` arrives 1 cycle after the 5th tick, after 3 ramp ticks and 2 settle ticks.
- Targets {250000, 50000, 150000}, step 0 → after the first tick, widths are 200000/100000/150000 (clamped).
- `abort` asserted mid-ramp at width 150200 with target 150500 → widths hold at 150200 and stay there across later ticks; no `done` pulse; `cmd_ready`=1 next cycle.
- `cmd_valid` held during RAMP → no acceptance until after `done`. `abort`+`cmd_valid` in IDLE → command accepted.
- `rst` asserted in SETTLE → next cycle all widths are 150000 and state is IDLE; no `done` pulse.
